// File: rtl/icache_pkg.sv
// Shared types, widths and state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned IDX_W       = 7;
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned LINES       = 1 << IDX_W;
  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_e;

  // One cache line: tag plus the single instruction word it holds
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    inst_bus_t        data;
  } line_t;

  function automatic logic [IDX_W-1:0] pc_idx(input inst_addr_bus_t pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input inst_addr_bus_t pc);
    return pc[IDX_W+2+TAG_W-1:IDX_W+2];
  endfunction

endpackage

// File: rtl/icache_ram.sv
// Valid/tag/data arrays: one combinational read port, one write port.
module icache_ram
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [31:0]      wr_data_i
);

  logic [LINES-1:0] valid_q;
  line_t            lines_q [LINES];
  line_t            wr_line;

  assign wr_line = '{tag: wr_tag_i, data: wr_data_i};

  // Valid bits are the only state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= True;
    end
  end

  // Tag/data storage, qualified by valid so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      lines_q[wr_idx_i] <= wr_line;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = lines_q[rd_idx_i].tag;
  assign rd_data_o  = lines_q[rd_idx_i].data;

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between IF and the memory controller fetch port.
// Define ICACHE_PERF_EN to add hit_cnt_o / miss_cnt_o request counters.
module icache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_pc_o,
  output logic        mc_fe_o,
  output logic [31:0] mc_fpc_o,
  input  logic [31:0] mc_inst_i,
  input  logic        mc_ok_i,
  input  logic [31:0] mc_pc_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  icache_state_e  state_q, state_d;
  inst_addr_bus_t miss_pc_q, miss_pc_d;
  logic           stale_q, stale_d;
  inst_bus_t      inst_q, inst_d;
  logic           inst_valid_q, inst_valid_d;
  inst_addr_bus_t inst_pc_q, inst_pc_d;
  logic           mc_fe_q, mc_fe_d;
  inst_addr_bus_t mc_fpc_q, mc_fpc_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  inst_bus_t        rd_data;
  logic             hit_c;
  logic             fill_c;
  logic             redirect_c;

  icache_ram u_ram (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pc_idx(if_pc_i)),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (rdy && fill_c),
    .wr_idx_i   (pc_idx(mc_pc_i)),
    .wr_tag_i   (pc_tag(mc_pc_i)),
    .wr_data_i  (mc_inst_i)
  );

  assign hit_c      = rd_valid && (rd_tag == pc_tag(if_pc_i));
  assign redirect_c = if_req_i && (if_pc_i != miss_pc_q);

  // Next-state and response logic; lookups are only made from IDLE, so a fill always wins
  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    stale_d      = stale_q;
    inst_d       = inst_q;
    inst_valid_d = False;
    inst_pc_d    = inst_pc_q;
    mc_fe_d      = mc_fe_q;
    mc_fpc_d     = mc_fpc_q;
    fill_c       = False;
    case (state_q)
      IDLE: begin
        if (if_req_i && !flush_i) begin
          if (hit_c) begin
            inst_valid_d = True;
            inst_d       = rd_data;
            inst_pc_d    = if_pc_i;
          end else begin
            miss_pc_d = if_pc_i;
            stale_d   = False;
            mc_fe_d   = True;
            mc_fpc_d  = if_pc_i;
            state_d   = MISS;
          end
        end
      end
      MISS: begin
        // Any returned word is correct for its own address, so it always fills its line
        fill_c = mc_ok_i;
        if (redirect_c) begin
          miss_pc_d = if_pc_i;
          mc_fpc_d  = if_pc_i;
          stale_d   = False;
        end else begin
          if (flush_i) begin
            stale_d = True;
          end
          if (mc_ok_i && (mc_pc_i == miss_pc_q)) begin
            if (!stale_q && !flush_i) begin
              inst_valid_d = True;
              inst_d       = mc_inst_i;
              inst_pc_d    = miss_pc_q;
            end
            mc_fe_d = False;
            stale_d = False;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      miss_pc_q    <= '0;
      stale_q      <= False;
      inst_q       <= '0;
      inst_valid_q <= False;
      inst_pc_q    <= '0;
      mc_fe_q      <= False;
      mc_fpc_q     <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      stale_q      <= stale_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      mc_fe_q      <= mc_fe_d;
      mc_fpc_q     <= mc_fpc_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_pc_o    = inst_pc_q;
  assign mc_fe_o      = mc_fe_q;
  assign mc_fpc_o     = mc_fpc_q;

`ifdef ICACHE_PERF_EN
  logic        acc_hit_c;
  logic        acc_miss_c;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  assign acc_hit_c  = (state_q == IDLE) && if_req_i && !flush_i && hit_c;
  assign acc_miss_c = (state_q == IDLE) && if_req_i && !flush_i && !hit_c;

  // Accepted-request counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      if (acc_hit_c)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (acc_miss_c) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetches against a line-level model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [31:0] inst_pc_o;
  logic        mc_fe_o;
  logic [31:0] mc_fpc_o;
  logic [31:0] mc_inst_i = '0;
  logic        mc_ok_i = 1'b0;
  logic [31:0] mc_pc_i = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .if_req_i     (if_req_i),
    .if_pc_i      (if_pc_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .inst_pc_o    (inst_pc_o),
    .mc_fe_o      (mc_fe_o),
    .mc_fpc_o     (mc_fpc_o),
    .mc_inst_i    (mc_inst_i),
    .mc_ok_i      (mc_ok_i),
    .mc_pc_i      (mc_pc_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Cache model: which address each of the 128 lines currently holds
  bit          m_valid [128];
  logic [31:0] m_addr  [128];
  int          m_hits  = 0;
  int          m_miss  = 0;

  // Memory contents as seen by the controller
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h0000_0013;
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc / 4) % 128);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[line_of(pc)] && (m_addr[line_of(pc)] == pc);
  endfunction

  function automatic void model_fill(input logic [31:0] pc);
    m_valid[line_of(pc)] = 1'b1;
    m_addr[line_of(pc)]  = pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Controller model: 5-cycle read that restarts when the fetch address changes
  bit          deliver_stale = 1'b0;
  bit          cur_valid = 1'b0;
  logic [31:0] cur_pc = '0;
  int          cnt = 0;

  always @(posedge clk) begin
    #1;
    if (rdy && !rst) begin
      mc_ok_i = 1'b0;
      if (!mc_fe_o) begin
        cur_valid = 1'b0;
        cnt = 0;
      end else if (!cur_valid || mc_fpc_o != cur_pc) begin
        if (cur_valid && deliver_stale) begin
          mc_ok_i   = 1'b1;
          mc_pc_i   = cur_pc;
          mc_inst_i = mem_word(cur_pc);
        end
        cur_pc = mc_fpc_o;
        cur_valid = 1'b1;
        cnt = 1;
      end else begin
        cnt++;
        if (cnt == 5) begin
          mc_ok_i   = 1'b1;
          mc_pc_i   = cur_pc;
          mc_inst_i = mem_word(cur_pc);
        end
      end
    end
  end

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!inst_valid_o && lat < 40);
  endtask

  // Full request: predicts hit/miss from the model, checks response, latency and single pulse
  task automatic fetch(input logic [31:0] pc, input string tag, output int lat);
    bit exp_hit;
    exp_hit  = model_hit(pc);
    if_pc_i  = pc;
    if_req_i = 1'b1;
    @(negedge clk);
    lat = 1;
    if (exp_hit) begin
      check({tag, " hit no fetch"}, 32'(mc_fe_o), 32'd0);
    end else begin
      check({tag, " fetch req"}, 32'(mc_fe_o), 32'd1);
      check({tag, " fetch addr"}, mc_fpc_o, pc);
    end
    while (!inst_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if_req_i = 1'b0;
    check({tag, " valid"}, 32'(inst_valid_o), 32'd1);
    check({tag, " data"}, inst_o, mem_word(pc));
    check({tag, " pc"}, inst_pc_o, pc);
    check({tag, " latency"}, 32'(lat), exp_hit ? 32'd1 : 32'd6);
    if (exp_hit) m_hits++; else m_miss++;
    model_fill(pc);
    @(negedge clk);
    check({tag, " single pulse"}, 32'(inst_valid_o), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] pc;

    // Reset
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst inst", inst_o, 32'd0);
    check("rst valid", 32'(inst_valid_o), 32'd0);
    check("rst inst_pc", inst_pc_o, 32'd0);
    check("rst fe", 32'(mc_fe_o), 32'd0);
    check("rst fpc", mc_fpc_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss then hit on 0x0
    fetch(32'h0, "cold", lat);
    check("cold is miss", 32'(lat), 32'd6);
    fetch(32'h0, "hit", lat);
    check("hit is hit", 32'(lat), 32'd1);

    // Conflict on index 0
    fetch(32'h200, "conflict", lat);
    check("conflict miss", 32'(lat), 32'd6);
    fetch(32'h0, "evicted", lat);
    check("evicted miss", 32'(lat), 32'd6);

    // Redirect mid-miss: abandoned word still fills its own line
    deliver_stale = 1'b1;
    if_pc_i  = 32'h40;
    if_req_i = 1'b1;
    m_miss++;
    repeat (2) @(negedge clk);
    if_pc_i = 32'h80;
    @(negedge clk);
    check("redirect fpc", mc_fpc_o, 32'h80);
    wait_resp(lat);
    if_req_i = 1'b0;
    deliver_stale = 1'b0;
    check("redirect valid", 32'(inst_valid_o), 32'd1);
    check("redirect pc", inst_pc_o, 32'h80);
    check("redirect data", inst_o, mem_word(32'h80));
    model_fill(32'h40);
    model_fill(32'h80);
    @(negedge clk);
    fetch(32'h40, "stale line", lat);
    check("stale line hit", 32'(lat), 32'd1);

    // Flush mid-miss: no response, line still filled
    if_pc_i  = 32'h100;
    if_req_i = 1'b1;
    m_miss++;
    @(negedge clk);
    if_req_i = 1'b0;
    flush_i  = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (inst_valid_o) pulses++;
    end
    check("flush no pulse", 32'(pulses), 32'd0);
    check("flush fill done", 32'(mc_fe_o), 32'd0);
    model_fill(32'h100);
    fetch(32'h100, "after flush", lat);
    check("after flush hit", 32'(lat), 32'd1);

    // rdy low for 3 cycles during a miss
    if_pc_i  = 32'h1C0;
    if_req_i = 1'b1;
    m_miss++;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      check("stall fe", 32'(mc_fe_o), 32'd1);
      check("stall fpc", mc_fpc_o, 32'h1C0);
      if (inst_valid_o) pulses++;
    end
    rdy = 1'b1;
    lat = 5;
    while (!inst_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if_req_i = 1'b0;
    check("stall no early pulse", 32'(pulses), 32'd0);
    check("stall latency", 32'(lat), 32'd9);
    check("stall data", inst_o, mem_word(32'h1C0));
    check("stall pc", inst_pc_o, 32'h1C0);
    model_fill(32'h1C0);
    @(negedge clk);

`ifdef ICACHE_PERF_EN
    check("perf hits", hit_cnt_o, 32'(m_hits));
    check("perf misses", miss_cnt_o, 32'(m_miss));
    fetch(32'h3F0, "perf m", lat);
    fetch(32'h3F0, "perf h1", lat);
    fetch(32'h3F0, "perf h2", lat);
    check("perf hits seq", hit_cnt_o, 32'(m_hits));
    check("perf misses seq", miss_cnt_o, 32'(m_miss));
`endif

    // Random fetches over a small address pool to mix hits and conflicts
    for (int i = 0; i < 60; i++) begin
      pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 2);
      fetch(pc, "rand", lat);
    end

`ifdef ICACHE_PERF_EN
    check("perf hits final", hit_cnt_o, 32'(m_hits));
    check("perf misses final", miss_cnt_o, 32'(m_miss));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller's instruction-fetch port.
- Hits return in one cycle.
- Misses drive the controller's instruction-fetch handshake (inst_fe / inst_fpc → inst_ok / inst_o / inst_pc), fill the line, then return the word.
- Tracks PC redirects during a miss so the controller restarts the fetch at the new address.

Parameters:
IDX_W, 7, index bits; 2^IDX_W one-word lines (128)
TAG_W, 8, tag bits taken from pc[IDX_W+2+TAG_W-1:IDX_W+2]; covers the 17-bit RAM space at defaults

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when low, all registers hold
if_req_i  in  1  IF stage requests the instruction at if_pc_i
if_pc_i  in  32  fetch PC, word aligned
flush_i  in  1  branch redirect; abandon the pending return to IF
inst_o  out  32  instruction to IF
inst_valid_o  out  1  one-cycle pulse; inst_o/inst_pc_o valid
inst_pc_o  out  32  PC of inst_o
mc_fe_o  out  1  fetch request to memory controller (inst_fe)
mc_fpc_o  out  32  fetch address to memory controller (inst_fpc)
mc_inst_i  in  32  returned word (inst_o of controller)
mc_ok_i  in  1  returned-word strobe (inst_ok)
mc_pc_i  in  32  address of returned word (inst_pc)

Behaviour:
- Reset (async, rst=1):
  - all valid bits cleared; state=IDLE.
  - inst_o=0, inst_valid_o=0, inst_pc_o=0, mc_fe_o=0, mc_fpc_o=0.
- rdy=0: no register changes; mc_ok_i arriving then is ignored (controller is also stalled).
- Lookup: idx=pc[IDX_W+1:2]; tag as in Parameters; hit = valid[idx] && tag_ram[idx]==tag.
- IDLE:
  - if_req_i && hit && !flush_i: next cycle inst_valid_o=1, inst_o=data, inst_pc_o=if_pc_i; stay IDLE. Back-to-back hits give one word per cycle.
  - if_req_i && miss && !flush_i: latch miss_pc=if_pc_i, mc_fe_o<=1, mc_fpc_o<=if_pc_i, go to MISS.
  - flush_i: no response, no new miss in that cycle.
- MISS:
  - mc_fe_o stays high and mc_fpc_o=miss_pc until the fill completes.
  - if_req_i with if_pc_i!=miss_pc (redirect): miss_pc and mc_fpc_o take the new PC. The controller detects the PC change and restarts.
  - flush_i without a new request: mark the response stale, keep fetching miss_pc. The fill still happens but nothing is returned to IF.
  - mc_ok_i && mc_pc_i==miss_pc:
    - write data/tag, set valid.
    - If not stale, pulse inst_valid_o with inst_o=mc_inst_i, inst_pc_o=miss_pc.
    - mc_fe_o<=0; return to IDLE.
  - mc_ok_i && mc_pc_i!=miss_pc (word from an abandoned fetch): write it into its own line (the data is correct for that address); no IF response; stay in MISS.
  - Fill and IF lookup of the same index in the same cycle: the fill wins; the lookup is evaluated the next cycle.
- inst_valid_o is high for exactly one cycle per response; never two responses for one PC.
- Latency: hit 1 cycle; miss = controller read latency (5 cycles after mc_fe_o rises) + 1.
- No writes from the data side; self-modifying code is not supported.

Optional Feature:
- ICACHE_PERF_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Each counts accepted IF requests (hit / miss-entry) while rdy=1.
  - Both reset to 0 and wrap at 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/defines: InstAddrBus, InstBus, True/False, and the ICACHE state encoding (IDLE=1'b0, MISS=1'b1).
- Sub-module icache_ram: IDX_W-indexed valid/tag/data arrays with one combinational read port and one write port; valid array cleared by rst.
- Control FSM and counters stay in icache.

Test Plan:
- Cold miss: rst, if_req_i=1, if_pc_i=0x0 → mc_fe_o=1, mc_fpc_o=0x0; model returns 0x00000013 → inst_valid_o pulse, inst_o=0x00000013, inst_pc_o=0x0.
- Hit: re-request 0x0 → inst_valid_o the next cycle with 0x00000013, mc_fe_o stays 0.
- Conflict: fill 0x0, then request 0x200 (same index, IDX_W=7) → miss; after fill, 0x0 misses again.
- Redirect mid-miss: miss on 0x40; two cycles later if_pc_i=0x80 → mc_fpc_o=0x80; stale word for 0x40 fills its own line with no IF pulse; the 0x80 word is returned.
- Flush mid-miss on 0x100 → no inst_valid_o; a later request to 0x100 hits.
- rdy low for 3 cycles during a miss → state and outputs frozen; completes normally after rdy returns. With ICACHE_PERF_EN: sequence miss, hit, hit → hit_cnt_o=2, miss_cnt_o=1.
